// File: rtl/mc_recon_controller_if.sv
// Row streams of the reconstruction controller: residual and prediction rows in, clamped rows out.
// slave is the controller side, master the surrounding environment.
interface mc_recon_controller_if #(
  parameter int MB_SIZE = 4,
  parameter int PIX_W   = 8,
  parameter int RES_W   = 9
);
  logic                     res_valid;
  logic                     res_ready;
  logic [MB_SIZE*RES_W-1:0] res_row;
  logic                     pred_valid;
  logic                     pred_ready;
  logic [MB_SIZE*PIX_W-1:0] pred_row;
  logic                     rec_valid;
  logic                     rec_ready;
  logic [MB_SIZE*PIX_W-1:0] rec_row;
  logic                     rec_blk_last;

  modport master (
    output res_valid, res_row, pred_valid, pred_row, rec_ready,
    input  res_ready, pred_ready, rec_valid, rec_row, rec_blk_last
  );

  modport slave (
    input  res_valid, res_row, pred_valid, pred_row, rec_ready,
    output res_ready, pred_ready, rec_valid, rec_row, rec_blk_last
  );
endinterface

// File: rtl/mc_recon_controller.sv
// Joins residual and prediction rows, adds and clamps to pixels, and sequences one luma/chroma pass.
// Optional clipped-lane statistics are enabled with `define MC_RECON_SAT_STATS_EN.
module mc_recon_controller #(
  parameter int MB_SIZE  = 4,
  parameter int PIX_W    = 8,
  parameter int RES_W    = 9,
  parameter int N_LUMA   = 16,
  parameter int N_CHROMA = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ccin,
  mc_recon_controller_if.slave  bus,
  output logic [3:0]            blk_idx,
  output logic                  busy,
  output logic                  XXINC,
  output logic                  CC_XXINC,
  output logic [15:0]           sat_count
);
  localparam int ROW_W = $clog2(MB_SIZE);
  localparam int BLK_W = 4;
  localparam logic signed [RES_W:0] PIX_MAX =
    $signed({{(RES_W+1-PIX_W){1'b0}}, {PIX_W{1'b1}}});

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LUMA   = 2'd1,
    ST_CHROMA = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                   state_r;
  logic                     chroma_r;
  logic [ROW_W-1:0]         row_cnt_r;
  logic [BLK_W-1:0]         blk_cnt_r;
  logic                     rec_valid_r;
  logic                     rec_blk_last_r;
  logic [MB_SIZE*PIX_W-1:0] rec_row_r;
  logic                     xxinc_r;
  logic                     cc_xxinc_r;

  logic                     in_pass_s;
  logic                     space_s;
  logic                     fire_s;
  logic                     row_last_s;
  logic                     blk_last_s;
  logic [MB_SIZE*PIX_W-1:0] rec_next_s;

  function automatic logic signed [RES_W:0] lane_sum(input logic [PIX_W-1:0] p,
                                                     input logic [RES_W-1:0] r);
    lane_sum = $signed({{(RES_W+1-PIX_W){1'b0}}, p}) + $signed({r[RES_W-1], r});
  endfunction

  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [RES_W:0] s);
    if (s[RES_W]) begin
      clamp_pix = {PIX_W{1'b0}};
    end else if (s > PIX_MAX) begin
      clamp_pix = {PIX_W{1'b1}};
    end else begin
      clamp_pix = s[PIX_W-1:0];
    end
  endfunction

  assign in_pass_s  = (state_r == ST_LUMA) || (state_r == ST_CHROMA);
  assign space_s    = !rec_valid_r || bus.rec_ready;
  // Join: a row moves only when both sources present it and the output slot is free
  assign fire_s     = in_pass_s && space_s && bus.res_valid && bus.pred_valid;
  assign row_last_s = (row_cnt_r == ROW_W'(MB_SIZE-1));
  assign blk_last_s = (state_r == ST_CHROMA) ? (blk_cnt_r == BLK_W'(N_CHROMA-1))
                                             : (blk_cnt_r == BLK_W'(N_LUMA-1));

  assign bus.res_ready    = fire_s;
  assign bus.pred_ready   = fire_s;
  assign bus.rec_valid    = rec_valid_r;
  assign bus.rec_row      = rec_row_r;
  assign bus.rec_blk_last = rec_blk_last_r;
  assign blk_idx          = blk_cnt_r;
  assign busy             = (state_r != ST_IDLE);
  assign XXINC            = xxinc_r;
  assign CC_XXINC         = cc_xxinc_r;

  // Per-lane add and clamp of the presented rows
  always_comb begin
    rec_next_s = '0;
    for (int i = 0; i < MB_SIZE; i++) begin
      rec_next_s[i*PIX_W +: PIX_W] =
        clamp_pix(lane_sum(bus.pred_row[i*PIX_W +: PIX_W], bus.res_row[i*RES_W +: RES_W]));
    end
  end

  // Pass sequencer with output row register and done pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      chroma_r       <= 1'b0;
      row_cnt_r      <= '0;
      blk_cnt_r      <= '0;
      rec_valid_r    <= 1'b0;
      rec_blk_last_r <= 1'b0;
      rec_row_r      <= '0;
      xxinc_r        <= 1'b0;
      cc_xxinc_r     <= 1'b0;
    end else begin
      xxinc_r    <= 1'b0;
      cc_xxinc_r <= 1'b0;

      if (fire_s) begin
        rec_row_r      <= rec_next_s;
        rec_blk_last_r <= row_last_s;
        rec_valid_r    <= 1'b1;
      end else if (bus.rec_ready) begin
        rec_valid_r    <= 1'b0;
      end else begin
        rec_valid_r    <= rec_valid_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            chroma_r <= ccin;
            state_r  <= ccin ? ST_CHROMA : ST_LUMA;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_LUMA, ST_CHROMA: begin
          if (fire_s) begin
            if (row_last_s) begin
              row_cnt_r <= '0;
              if (blk_last_s) begin
                blk_cnt_r <= '0;
                state_r   <= ST_DONE;
              end else begin
                blk_cnt_r <= blk_cnt_r + BLK_W'(1);
              end
            end else begin
              row_cnt_r <= row_cnt_r + ROW_W'(1);
            end
          end else begin
            row_cnt_r <= row_cnt_r;
          end
        end
        ST_DONE: begin
          // The done pulse waits until the final row has left the output register
          if (!rec_valid_r || bus.rec_ready) begin
            xxinc_r    <= !chroma_r;
            cc_xxinc_r <= chroma_r;
            state_r    <= ST_IDLE;
          end else begin
            state_r    <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MC_RECON_SAT_STATS_EN
  localparam int CLIP_W = $clog2(MB_SIZE+1);

  logic [15:0]       sat_count_r;
  logic [CLIP_W-1:0] clip_cnt_s;
  logic [16:0]       sat_sum_s;

  function automatic logic lane_clipped(input logic signed [RES_W:0] s);
    lane_clipped = s[RES_W] || (s > PIX_MAX);
  endfunction

  // Number of lanes of the presented row that hit either clamp bound
  always_comb begin
    clip_cnt_s = '0;
    for (int i = 0; i < MB_SIZE; i++) begin
      clip_cnt_s = clip_cnt_s + CLIP_W'(lane_clipped(
        lane_sum(bus.pred_row[i*PIX_W +: PIX_W], bus.res_row[i*RES_W +: RES_W])));
    end
  end

  assign sat_sum_s = {1'b0, sat_count_r} + 17'(clip_cnt_s);
  assign sat_count = sat_count_r;

  // Saturating per-pass clip counter, cleared when a pass is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count_r <= 16'h0000;
    end else if ((state_r == ST_IDLE) && start) begin
      sat_count_r <= 16'h0000;
    end else if (fire_s) begin
      sat_count_r <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
    end else begin
      sat_count_r <= sat_count_r;
    end
  end
`else
  assign sat_count = 16'h0000;
`endif
endmodule

// File: tb/tb_mc_recon_controller.sv
// Directed + randomized bench for mc_recon_controller against a row-level reference model.
module tb_mc_recon_controller;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ccin;
  logic [3:0]  blk_idx;
  logic        busy;
  logic        XXINC;
  logic        CC_XXINC;
  logic [15:0] sat_count;

  mc_recon_controller_if bus ();

  mc_recon_controller dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ccin      (ccin),
    .bus       (bus),
    .blk_idx   (blk_idx),
    .busy      (busy),
    .XXINC     (XXINC),
    .CC_XXINC  (CC_XXINC),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 in pass, 2 waiting to report done
  int          m_state;
  bit          m_chroma;
  int          m_rows;
  bit          m_rv;
  logic [31:0] m_row;
  bit          m_last;
  bit          m_xx;
  bit          m_cc;
  int          m_sat;
  int          n_xx;
  int          n_cc;
  int          n_out;

  function automatic int ref_pix(int p, int r);
    int s;
    s = p + r;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_chroma = 1'b0; m_rows = 0; m_rv = 1'b0; m_row = '0;
    m_last = 1'b0; m_xx = 1'b0; m_cc = 1'b0; m_sat = 0;
  endtask

  task automatic idle_inputs();
    start = 1'b0; ccin = 1'b0;
    bus.res_valid = 1'b0; bus.pred_valid = 1'b0; bus.rec_ready = 1'b1;
    bus.res_row = '0; bus.pred_row = '0;
  endtask

  task automatic step();
    bit          fire;
    bit          drain;
    int          total;
    int          p;
    int          r;
    int          v;
    int          nclip;
    logic [31:0] nrow;
    @(negedge clk);
    fire = (m_state == 1) && (!m_rv || bus.rec_ready) && bus.res_valid && bus.pred_valid;
    chk("res_ready", 32'(bus.res_ready), 32'(fire));
    chk("pred_ready", 32'(bus.pred_ready), 32'(fire));
    chk("rec_valid", 32'(bus.rec_valid), 32'(m_rv));
    if (m_rv) begin
      chk("rec_row", bus.rec_row, m_row);
      chk("rec_blk_last", 32'(bus.rec_blk_last), 32'(m_last));
    end
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("blk_idx", 32'(blk_idx), 32'(m_rows / MB));
    chk("XXINC", 32'(XXINC), 32'(m_xx));
    chk("CC_XXINC", 32'(CC_XXINC), 32'(m_cc));
`ifdef MC_RECON_SAT_STATS_EN
    chk("sat_count", 32'(sat_count), 32'(m_sat));
`else
    chk("sat_count", 32'(sat_count), 32'd0);
`endif
    n_xx  += int'(XXINC);
    n_cc  += int'(CC_XXINC);
    n_out += int'(bus.rec_valid && bus.rec_ready);

    drain = !m_rv || bus.rec_ready;
    m_xx = 1'b0;
    m_cc = 1'b0;
    if (fire) begin
      nclip = 0;
      nrow  = '0;
      for (int i = 0; i < MB; i++) begin
        p = int'(bus.pred_row[i*8 +: 8]);
        r = int'($signed(bus.res_row[i*9 +: 9]));
        v = ref_pix(p, r);
        if (v != p + r) nclip++;
        nrow[i*8 +: 8] = 8'(v);
      end
      m_row  = nrow;
      m_last = ((m_rows % MB) == MB - 1);
      m_rv   = 1'b1;
      m_sat  = (m_sat + nclip > 65535) ? 65535 : m_sat + nclip;
    end else if (bus.rec_ready) begin
      m_rv = 1'b0;
    end
    total = m_chroma ? 32 : 64;
    case (m_state)
      0: if (start) begin m_state = 1; m_chroma = ccin; m_rows = 0; m_sat = 0; end
      1: if (fire) begin
           m_rows++;
           if (m_rows == total) begin m_rows = 0; m_state = 2; end
         end
      2: if (drain) begin
           if (m_chroma) m_cc = 1'b1; else m_xx = 1'b1;
           m_state = 0;
         end
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_lane(int i, int p, int r);
    bus.pred_row[i*8 +: 8] = 8'(p);
    bus.res_row[i*9 +: 9]  = 9'(r);
  endtask

  // mode 0: constant 100/+5 stream; 1: random data, gaps, backpressure; 2: clamp rows
  task automatic drive(int mode);
    int a_p[4] = '{250, 3, 0, 100};
    int a_r[4] = '{10, -20, -256, 5};
    int b_p[4] = '{255, 0, 250, 3};
    int b_r[4] = '{255, -256, 10, 3};
    case (mode)
      0: begin
        bus.res_valid = 1'b1; bus.pred_valid = 1'b1; bus.rec_ready = 1'b1;
        for (int i = 0; i < MB; i++) set_lane(i, 100, 5);
      end
      2: begin
        bus.res_valid = 1'b1; bus.pred_valid = 1'b1; bus.rec_ready = 1'b1;
        for (int i = 0; i < MB; i++) begin
          if ((m_rows % MB) != 0) set_lane(i, 100, 5);
          else if (((m_rows / MB) % 2) == 0) set_lane(i, a_p[i], a_r[i]);
          else set_lane(i, b_p[i], b_r[i]);
        end
      end
      default: begin
        bus.res_valid  = ($urandom_range(0, 3) != 0);
        bus.pred_valid = ($urandom_range(0, 3) != 0);
        bus.rec_ready  = ($urandom_range(0, 3) != 0);
        start          = ($urandom_range(0, 7) == 0);
        ccin           = $urandom_range(0, 1) == 1;
        for (int i = 0; i < MB; i++) begin
          case ($urandom_range(0, 3))
            0: bus.res_row[i*9 +: 9] = 9'h100;
            1: bus.res_row[i*9 +: 9] = 9'h0FF;
            default: bus.res_row[i*9 +: 9] = 9'($urandom_range(0, 511));
          endcase
          bus.pred_row[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
      end
    endcase
  endtask

  task automatic begin_pass(bit c);
    idle_inputs();
    start = 1'b1;
    ccin  = c;
    step();
    start = 1'b0;
  endtask

  task automatic finish_pass(int mode, int maxc);
    for (int c = 0; c < maxc && m_state != 0; c++) begin
      drive(mode);
      step();
    end
    idle_inputs();
    chk("pass_ends", 32'(busy), 32'd0);
    step();
  endtask

  task automatic clear_counts();
    n_xx = 0; n_cc = 0; n_out = 0;
  endtask

  initial begin
    clear_counts();
    model_reset();
    do_reset();
    step();

    // Luma pass, 1 row per cycle, 105 everywhere
    clear_counts();
    begin_pass(1'b0);
    finish_pass(0, 200);
    chk("luma_xxinc_pulses", 32'(n_xx), 32'd1);
    chk("luma_cc_pulses", 32'(n_cc), 32'd0);
    chk("luma_rows_out", 32'(n_out), 32'd64);

    // Clamp pass: 3 clipped lanes in the first row of every block
    begin_pass(1'b0);
    finish_pass(2, 200);
`ifdef MC_RECON_SAT_STATS_EN
    chk("sat_after_pass", 32'(sat_count), 32'd48);
`else
    chk("sat_after_pass", 32'(sat_count), 32'd0);
`endif

    // Backpressure, then prediction missing
    begin_pass(1'b0);
    for (int c = 0; c < 6; c++) begin drive(0); step(); end
    bus.rec_ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    bus.rec_ready = 1'b1; bus.pred_valid = 1'b0;
    for (int c = 0; c < 3; c++) step();
    chk("bp_blk_idx", 32'(blk_idx), 32'd1);
    finish_pass(1, 2000);

    // Chroma pass with stray starts
    clear_counts();
    begin_pass(1'b1);
    finish_pass(1, 2000);
    chk("chroma_cc_pulses", 32'(n_cc), 32'd1);
    chk("chroma_xx_pulses", 32'(n_xx), 32'd0);

    // Reset at block 5 row 2
    clear_counts();
    begin_pass(1'b0);
    for (int c = 0; c < 2000 && m_rows != 22; c++) begin drive(1); step(); end
    chk("mid_blk_idx", 32'(blk_idx), 32'd5);
    do_reset();
    for (int c = 0; c < 4; c++) step();
    chk("reset_no_pulse", 32'(n_xx + n_cc), 32'd0);

    // Extra random passes
    for (int k = 0; k < 4; k++) begin
      clear_counts();
      begin_pass(k[0]);
      finish_pass(1, 2000);
      chk("rand_pulse", 32'(k[0] ? n_cc : n_xx), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
